inst_fetch_ctrl: RTL and testbench

//  Fetch-stage controller on the read side of the PC register. Takes the current PC,

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: PC-side inputs, imem SRAM-like read channel and decode-side outputs.
// master = fetch controller, slave = environment (PC register, imem, decode).
interface inst_fetch_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] pc_i;
   logic             flush;
   logic             ds_allowin;
   logic             inst_req;
   logic [WIDTH-1:0] inst_addr;
   logic             inst_addr_ok;
   logic             inst_data_ok;
   logic [WIDTH-1:0] inst_rdata;
   logic             fs_valid;
   logic [WIDTH-1:0] fs_pc;
   logic [WIDTH-1:0] fs_inst;
   logic             fs_adel;
   logic             pc_en;

   modport master (
      input  pc_i, flush, ds_allowin, inst_addr_ok, inst_data_ok, inst_rdata,
      output inst_req, inst_addr, fs_valid, fs_pc, fs_inst, fs_adel, pc_en
   );

   modport slave (
      output pc_i, flush, ds_allowin, inst_addr_ok, inst_data_ok, inst_rdata,
      input  inst_req, inst_addr, fs_valid, fs_pc, fs_inst, fs_adel, pc_en
   );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: one outstanding imem read per PC, single-entry buffer to decode,
// pc_en pulse on acceptance, in-flight responses discarded after a flush.
module inst_fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
   input logic          clk,
   input logic          rst,
   inst_fetch_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic             fresh_q, fresh_d;
   logic             discard_q, discard_d;
   logic             fs_valid_q, fs_valid_d;
   logic [WIDTH-1:0] fs_pc_q, fs_pc_d;
   logic [WIDTH-1:0] fs_inst_q, fs_inst_d;
   logic             fs_adel_q, fs_adel_d;
   logic             inst_req_c;
   logic             pc_en_c;
   logic             misalign;
   logic [WIDTH-1:0] req_addr;

   // pc_i is only valid for the new fetch in the first REQ cycle (the PC advances on the
   // pc_en edge), so that cycle drives pc_i directly and later cycles replay the latch.
   assign req_addr = fresh_q ? bus.pc_i : addr_q;
   assign misalign = fresh_q && (bus.pc_i[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      discard_d  = discard_q;
      fs_pc_d    = fs_pc_q;
      fs_inst_d  = fs_inst_q;
      fs_adel_d  = fs_adel_q;
      inst_req_c = 1'b0;
      pc_en_c    = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (fresh_q) addr_d = bus.pc_i;
            if (misalign) begin
               if (bus.flush) begin
                  state_d = S_IDLE;
               end else begin
                  fs_pc_d   = bus.pc_i;
                  fs_inst_d = '0;
                  fs_adel_d = 1'b1;
                  state_d   = S_HOLD;
               end
            end else begin
               inst_req_c = 1'b1;
               if (bus.flush) discard_d = 1'b1;
               if (bus.inst_addr_ok) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.inst_data_ok) begin
               if (discard_q || bus.flush) begin
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  fs_inst_d = bus.inst_rdata;
                  fs_pc_d   = addr_q;
                  fs_adel_d = 1'b0;
                  state_d   = S_HOLD;
               end
            end else if (bus.flush) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (bus.ds_allowin) begin
               pc_en_c = 1'b1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      fresh_d    = (state_d == S_REQ) && (state_q != S_REQ);
      fs_valid_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         fresh_q    <= 1'b0;
         discard_q  <= 1'b0;
         fs_valid_q <= 1'b0;
         fs_pc_q    <= RESET_PC;
         fs_inst_q  <= '0;
         fs_adel_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         fresh_q    <= fresh_d;
         discard_q  <= discard_d;
         fs_valid_q <= fs_valid_d;
         fs_pc_q    <= fs_pc_d;
         fs_inst_q  <= fs_inst_d;
         fs_adel_q  <= fs_adel_d;
      end
   end

   assign bus.inst_req  = inst_req_c;
   assign bus.inst_addr = (state_q == S_REQ) ? req_addr : addr_q;
   assign bus.fs_valid  = fs_valid_q;
   assign bus.fs_pc     = fs_pc_q;
   assign bus.fs_inst   = fs_inst_q;
   assign bus.fs_adel   = fs_adel_q;
   assign bus.pc_en     = pc_en_c;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: PC register, imem and decode modelled around the DUT; a queue of
// expected decode deliveries is checked by a separate monitor on every pc_en.
module tb_inst_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'hbfc00000;
   localparam logic [31:0] POISON = 32'hdeadbeef;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   inst_fetch_if #(.WIDTH(32)) bus ();

   inst_fetch_ctrl #(.WIDTH(32), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   exp_t exp_q[$];

   // stimulus knobs: mode 0/1 = constant, 2 = random with the given percentage
   int          allow_mode, allow_pct, aok_mode, aok_pct;
   int          dmin, dmax, flush_pct, spur_pct;
   logic        flush_req, poison;
   logic [31:0] flush_tgt, next_pc;
   logic        pend;
   int          cnt, idle_cnt, delivered;
   logic [31:0] paddr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == RST_PC) return 32'h24080001;
      return {a[15:0], a[31:16]} ^ 32'h13579bdf;
   endfunction

   function automatic exp_t mk(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.adel = (pc[1:0] != 2'b00);
      e.inst = e.adel ? 32'h0 : memf(pc);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rand_tgt();
      logic [31:0] t;
      t = RST_PC + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 99) < 10) t = t + 32'd2;
      return t;
   endfunction

   // one clock: drive inputs at negedge, then react to the settled combinational outputs
   task automatic step();
      logic [31:0] tgt;
      @(negedge clk);
      bus.pc_i  = next_pc;
      bus.flush = flush_req || ($urandom_range(0, 99) < flush_pct);
      tgt       = flush_req ? flush_tgt : rand_tgt();
      flush_req = 1'b0;
      bus.ds_allowin   = (allow_mode == 2) ? ($urandom_range(0, 99) < allow_pct) : allow_mode[0];
      bus.inst_addr_ok = (aok_mode == 2) ? ($urandom_range(0, 99) < aok_pct) : aok_mode[0];
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = $urandom;
      if (pend) begin
         if (cnt == 0) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = poison ? POISON : memf(paddr);
            pend   = 1'b0;
            poison = 1'b0;
         end else begin
            cnt--;
         end
      end else if ($urandom_range(0, 99) < spur_pct) begin
         bus.inst_data_ok = 1'b1;
      end
      #1;
      if (bus.inst_req && bus.inst_addr_ok) begin
         pend  = 1'b1;
         paddr = bus.inst_addr;
         cnt   = $urandom_range(dmin, dmax) - 1;
      end
      if (bus.flush) begin
         exp_q.delete();
         next_pc = tgt;
         exp_q.push_back(mk(tgt));
      end else if (bus.pc_en) begin
         next_pc = next_pc + 32'd4;
         exp_q.push_back(mk(next_pc));
      end
      if (bus.pc_en || bus.flush) idle_cnt = 0;
      else idle_cnt++;
   endtask

   task automatic wait_req(input logic [31:0] a, input string nm);
      for (int n = 0; n < 30; n++) begin
         step();
         if (bus.inst_req) break;
      end
      chk({nm, "_req"}, {31'h0, bus.inst_req}, 32'h1);
      chk(nm, bus.inst_addr, a);
   endtask

   task automatic wait_deliver(input string nm);
      for (int n = 0; n < 30; n++) begin
         step();
         if (bus.pc_en) break;
      end
      chk(nm, {31'h0, bus.pc_en}, 32'h1);
   endtask

   // monitor: scoreboard pops on each decode acceptance, plus request-channel invariants
   initial begin
      logic        prev_wait;
      logic [31:0] prev_addr;
      exp_t        e;
      prev_wait = 1'b0;
      prev_addr = '0;
      delivered = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_wait = 1'b0;
         end else begin
            if (bus.pc_en) begin
               chk("pc_en_valid", {31'h0, bus.fs_valid}, 32'h1);
               if (exp_q.size() == 0) begin
                  chk("sb_empty", 32'h1, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", bus.fs_pc, e.pc);
                  chk("sb_inst", bus.fs_inst, e.inst);
                  chk("sb_adel", {31'h0, bus.fs_adel}, {31'h0, e.adel});
                  delivered++;
               end
            end
            if (prev_wait) begin
               chk("hold_req", {31'h0, bus.inst_req}, 32'h1);
               chk("hold_addr", bus.inst_addr, prev_addr);
            end
            if (bus.inst_req) chk("req_align", {30'h0, bus.inst_addr[1:0]}, 32'h0);
            prev_wait = bus.inst_req && !bus.inst_addr_ok;
            prev_addr = bus.inst_addr;
         end
      end
   end

   initial begin
      logic saw;
      rst = 1'b1;
      bus.pc_i = RST_PC; bus.flush = 1'b0; bus.ds_allowin = 1'b0;
      bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
      next_pc = RST_PC; flush_req = 1'b0; flush_tgt = '0; poison = 1'b0;
      pend = 1'b0; cnt = 0; paddr = '0; idle_cnt = 0;
      allow_mode = 0; allow_pct = 70; aok_mode = 1; aok_pct = 60;
      dmin = 1; dmax = 1; flush_pct = 0; spur_pct = 0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_fs_pc", bus.fs_pc, RST_PC);
      chk("rst_fs_valid", {31'h0, bus.fs_valid}, 32'h0);
      chk("rst_inst_req", {31'h0, bus.inst_req}, 32'h0);
      chk("rst_inst_addr", bus.inst_addr, 32'h0);
      chk("rst_fs_inst", bus.fs_inst, 32'h0);
      chk("rst_fs_adel", {31'h0, bus.fs_adel}, 32'h0);
      chk("rst_pc_en", {31'h0, bus.pc_en}, 32'h0);
      exp_q.push_back(mk(RST_PC));
      @(negedge clk);
      rst = 1'b0;

      // zero-wait fetch: addr_ok c0, data_ok c1, fs_valid c2
      step();
      chk("c0_req", {31'h0, bus.inst_req}, 32'h1);
      chk("c0_addr", bus.inst_addr, RST_PC);
      step();
      chk("c1_valid", {31'h0, bus.fs_valid}, 32'h0);
      step();
      chk("c2_valid", {31'h0, bus.fs_valid}, 32'h1);
      chk("c2_inst", bus.fs_inst, 32'h24080001);
      chk("c2_pc", bus.fs_pc, RST_PC);

      // decode stall
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'h0, bus.fs_valid}, 32'h1);
         chk("stall_inst", bus.fs_inst, 32'h24080001);
         chk("stall_pc_en", {31'h0, bus.pc_en}, 32'h0);
      end
      allow_mode = 1; dmin = 3; dmax = 3;
      step();
      chk("release_pc_en", {31'h0, bus.pc_en}, 32'h1);
      step();
      chk("next_req", {31'h0, bus.inst_req}, 32'h1);
      chk("next_addr", bus.inst_addr, RST_PC + 32'd4);
      chk("single_pulse", {31'h0, bus.pc_en}, 32'h0);

      // flush while waiting: the late poisoned response must never reach decode
      flush_req = 1'b1; flush_tgt = 32'hbfc00380; poison = 1'b1;
      step();
      dmin = 1; dmax = 1;
      saw = 1'b0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (bus.fs_valid && bus.fs_inst == POISON) saw = 1'b1;
         if (bus.inst_req) break;
      end
      chk("poison_dropped", {31'h0, saw}, 32'h0);
      chk("redir_req", {31'h0, bus.inst_req}, 32'h1);
      chk("redir_addr", bus.inst_addr, 32'hbfc00380);
      wait_deliver("redir_deliver");

      // flush in REQ with addr_ok held off 3 cycles
      aok_mode = 0;
      wait_req(32'hbfc00384, "req_flush_addr");
      flush_req = 1'b1; flush_tgt = 32'hbfc00400;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("req_flush_hold", bus.inst_addr, 32'hbfc00384);
      end
      aok_mode = 1; allow_mode = 0;
      step();
      chk("req_flush_accept", bus.inst_addr, 32'hbfc00384);
      wait_req(32'hbfc00400, "refetch_addr");
      for (int n = 0; n < 10; n++) begin
         step();
         if (bus.fs_valid) break;
      end
      chk("refetch_pc", bus.fs_pc, 32'hbfc00400);
      chk("refetch_inst", bus.fs_inst, memf(32'hbfc00400));

      // unaligned PC: exception without a memory request
      flush_req = 1'b1; flush_tgt = 32'hbfc00002;
      step();
      saw = 1'b0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (bus.inst_req) saw = 1'b1;
         if (bus.fs_valid) break;
      end
      chk("adel_no_req", {31'h0, saw}, 32'h0);
      chk("adel_valid", {31'h0, bus.fs_valid}, 32'h1);
      chk("adel_flag", {31'h0, bus.fs_adel}, 32'h1);
      chk("adel_pc", bus.fs_pc, 32'hbfc00002);
      chk("adel_inst", bus.fs_inst, 32'h0);
      allow_mode = 1;
      wait_deliver("adel_deliver");

      // randomized traffic against the scoreboard
      allow_mode = 2; aok_mode = 2; dmin = 1; dmax = 4; flush_pct = 3; spur_pct = 10;
      idle_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (idle_cnt > 200) begin
            chk("watchdog", idle_cnt, 32'h0);
            break;
         end
      end
      chk("random_progress", {31'h0, delivered > 200}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
